spindle_star_delta_seq: RTL and testbench

Downstream consumer of the lathe control stage's `Control` run request. It sequences the spindle motor's star-delta contactors: main contactor, star winding, an enforced dead interval, then delta winding. E-stop and overload trips latch a fault. A minimum off-time is enforced before any restart. Its outputs drive the contactor relay drivers directly.

---
 rtl/spindle_star_delta_seq_pkg.sv | 18 +
 rtl/spindle_star_delta_seq_timer.sv | 28 ++
 rtl/spindle_star_delta_seq.sv | 149 ++++++++++++++
 tb/tb_spindle_star_delta_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/spindle_star_delta_seq_pkg.sv
// Shared lathe-control definitions: sequencer state encoding and default phase presets.
package lathe_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_STAR     = 3'd1,
      ST_DEAD     = 3'd2,
      ST_DELTA    = 3'd3,
      ST_COOLDOWN = 3'd4,
      ST_FAULT    = 3'd5
   } state_t;

   localparam int unsigned STAR_CYCLES_DEF    = 20;
   localparam int unsigned DEAD_CYCLES_DEF    = 4;
   localparam int unsigned RESTART_CYCLES_DEF = 10;
   localparam int unsigned CNT_W_DEF          = 8;

endpackage

// File: rtl/spindle_star_delta_seq_timer.sv
// Phase interval timer: counts enabled cycles, flags the last cycle of a preset interval.
module seq_interval_timer
   import lathe_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] preset,
   output logic             done
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en)
         count <= count + CNT_W'(1);
   end

   assign done = (count == preset - CNT_W'(1));

endmodule

// File: rtl/spindle_star_delta_seq.sv
// Star-delta spindle contactor sequencer with latched trip fault and enforced restart off-time.
module spindle_star_delta_seq
   import lathe_ctrl_pkg::*;
#(
   parameter int unsigned STAR_CYCLES    = STAR_CYCLES_DEF,
   parameter int unsigned DEAD_CYCLES    = DEAD_CYCLES_DEF,
   parameter int unsigned RESTART_CYCLES = RESTART_CYCLES_DEF,
   parameter int unsigned CNT_W          = CNT_W_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ena,
   input  logic       run_req,
   input  logic       estop,
   input  logic       ovl,
   input  logic       fault_clr,
   output logic       k_main,
   output logic       k_star,
   output logic       k_delta,
   output logic       running,
   output logic       fault,
   output logic [2:0] state_o
);

   state_t           state;
   state_t           state_nxt;
   logic             trip;
   logic             timed;
   logic             tmr_clr;
   logic             tmr_en;
   logic             tmr_done;
   logic [CNT_W-1:0] preset;

   assign trip = estop | ovl;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Trips bypass the enable; illegal codes fall to FAULT through the default arm.
   always_comb begin
      state_nxt = state;
      if (trip) begin
         state_nxt = ST_FAULT;
      end else begin
         case (state)
            ST_IDLE: begin
               if (ena && run_req)
                  state_nxt = ST_STAR;
            end
            ST_STAR: begin
               if (ena) begin
                  if (!run_req)
                     state_nxt = ST_COOLDOWN;
                  else if (tmr_done)
                     state_nxt = ST_DEAD;
               end
            end
            ST_DEAD: begin
               if (ena) begin
                  if (!run_req)
                     state_nxt = ST_COOLDOWN;
                  else if (tmr_done)
                     state_nxt = ST_DELTA;
               end
            end
            ST_DELTA: begin
               if (ena && !run_req)
                  state_nxt = ST_COOLDOWN;
            end
            ST_COOLDOWN: begin
               if (ena && tmr_done)
                  state_nxt = ST_IDLE;
            end
            ST_FAULT: begin
               if (ena && fault_clr)
                  state_nxt = ST_COOLDOWN;
            end
            default: state_nxt = ST_FAULT;
         endcase
      end
   end

   always_comb begin
      timed  = 1'b0;
      preset = '0;
      case (state)
         ST_STAR: begin
            timed  = 1'b1;
            preset = CNT_W'(STAR_CYCLES);
         end
         ST_DEAD: begin
            timed  = 1'b1;
            preset = CNT_W'(DEAD_CYCLES);
         end
         ST_COOLDOWN: begin
            timed  = 1'b1;
            preset = CNT_W'(RESTART_CYCLES);
         end
         default: ;
      endcase
   end

   assign tmr_clr = (state_nxt != state) || !timed;
   assign tmr_en  = ena && timed;

   seq_interval_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clr    (tmr_clr),
      .en     (tmr_en),
      .preset (preset),
      .done   (tmr_done)
   );

   always_comb begin
      k_main  = 1'b0;
      k_star  = 1'b0;
      k_delta = 1'b0;
      running = 1'b0;
      fault   = 1'b0;
      case (state)
         ST_STAR: begin
            k_main = 1'b1;
            k_star = 1'b1;
         end
         ST_DEAD: begin
            k_main = 1'b1;
         end
         ST_DELTA: begin
            k_main  = 1'b1;
            k_delta = 1'b1;
            running = 1'b1;
         end
         ST_FAULT: begin
            fault = 1'b1;
         end
         default: ;
      endcase
   end

   assign state_o = state;

endmodule

// File: tb/tb_spindle_star_delta_seq.sv
// Self-checking bench: directed phase scenarios plus randomized traffic against a phase-deadline model.
module tb_spindle_star_delta_seq;

   localparam int STAR_N    = 20;
   localparam int DEAD_N    = 4;
   localparam int RESTART_N = 10;

   logic       clk = 1'b0;
   logic       reset;
   logic       ena, run_req, estop, ovl, fault_clr;
   logic       k_main, k_star, k_delta, running, fault;
   logic [2:0] state_o;

   int checks   = 0;
   int failures = 0;

   // Model: phase name plus cycles remaining before the timed phase ends.
   int m_phase;
   int m_left;
   logic [2:0] trace[$];
   logic prev_star, prev_delta;

   spindle_star_delta_seq #(
      .STAR_CYCLES    (STAR_N),
      .DEAD_CYCLES    (DEAD_N),
      .RESTART_CYCLES (RESTART_N),
      .CNT_W          (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ena       (ena),
      .run_req   (run_req),
      .estop     (estop),
      .ovl       (ovl),
      .fault_clr (fault_clr),
      .k_main    (k_main),
      .k_star    (k_star),
      .k_delta   (k_delta),
      .running   (running),
      .fault     (fault),
      .state_o   (state_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int phase_len(input int ph);
      case (ph)
         1: return STAR_N;
         2: return DEAD_N;
         4: return RESTART_N;
         default: return 0;
      endcase
   endfunction

   task automatic model_enter(input int ph);
      m_phase = ph;
      m_left  = phase_len(ph);
   endtask

   task automatic model_step(input logic r, e, es, ov, fc);
      if (es || ov)
         model_enter(5);
      else if (e) begin
         case (m_phase)
            0: if (r) model_enter(1);
            1, 2: begin
               if (!r)              model_enter(4);
               else if (m_left == 1) model_enter(m_phase + 1);
               else                 m_left--;
            end
            3: if (!r) model_enter(4);
            4: begin
               if (m_left == 1) model_enter(0);
               else             m_left--;
            end
            5: if (fc) model_enter(4);
            default: model_enter(5);
         endcase
      end
   endtask

   task automatic step(input logic r, e, es, ov, fc);
      run_req = r; ena = e; estop = es; ovl = ov; fault_clr = fc;
      @(posedge clk);
      model_step(r, e, es, ov, fc);
      #1;
      check("state_o", state_o, m_phase);
      check("k_main",  k_main,  (m_phase >= 1 && m_phase <= 3));
      check("k_star",  k_star,  (m_phase == 1));
      check("k_delta", k_delta, (m_phase == 3));
      check("running", running, (m_phase == 3));
      check("fault",   fault,   (m_phase == 5));
      trace.push_back(state_o);
   endtask

   task automatic run_until(input logic [2:0] target, input int max);
      int n = 0;
      while (state_o !== target && n < max) begin
         step(1, 1, 0, 0, 0);
         n++;
      end
      check("reach", state_o, target);
   endtask

   function automatic int count_of(input logic [2:0] v);
      int c = 0;
      foreach (trace[i]) if (trace[i] == v) c++;
      return c;
   endfunction

   function automatic int first_of(input logic [2:0] v);
      foreach (trace[i]) if (trace[i] == v) return i;
      return -1;
   endfunction

   // Contactor safety invariants, every cycle outside reset.
   always @(negedge clk) begin
      if (reset) begin
         prev_star  = 1'b0;
         prev_delta = 1'b0;
      end else begin
         check("excl", k_star & k_delta, 0);
         check("adjacent", (prev_star & k_delta) | (prev_delta & k_star), 0);
         check("main_off", (k_star | k_delta) & ~k_main, 0);
         prev_star  = k_star;
         prev_delta = k_delta;
      end
   end

   initial begin
      logic r, e;
      reset = 1'b1;
      run_req = 0; ena = 0; estop = 0; ovl = 0; fault_clr = 0;
      m_phase = 0; m_left = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", state_o, 0);
      check("rst_outs", {k_main, k_star, k_delta, running, fault}, 0);
      reset = 1'b0;

      // Normal start
      trace.delete();
      repeat (40) step(1, 1, 0, 0, 0);
      check("star_first", first_of(1), 0);
      check("star_len",   count_of(1), STAR_N);
      check("dead_len",   count_of(2), DEAD_N);
      check("delta_at",   first_of(3), STAR_N + DEAD_N);

      // Stop in DELTA, restart with run held high
      trace.delete();
      step(0, 1, 0, 0, 0);
      repeat (12) step(1, 1, 0, 0, 0);
      check("cool_len",   count_of(4), RESTART_N);
      check("idle_at",    first_of(0), RESTART_N);
      check("restart_at", first_of(1), RESTART_N + 1);

      // Mid-star abort at star clock 7
      repeat (5) step(1, 1, 0, 0, 0);
      trace.delete();
      step(0, 1, 0, 0, 0);
      check("abort_cool", state_o, 4);
      repeat (15) step(0, 1, 0, 0, 0);
      check("abort_nodelta", count_of(3), 0);

      // Overload in DEAD
      run_until(2, 60);
      step(1, 1, 0, 1, 0);
      check("ovl_fault", fault, 1);
      check("ovl_main",  k_main, 0);
      step(1, 1, 0, 1, 1);
      check("clr_blocked", state_o, 5);
      trace.delete();
      repeat (12) step(0, 1, 0, 0, 1);
      check("clr_cool", count_of(4), RESTART_N);
      check("clr_idle", trace[RESTART_N], 0);

      // Enable freeze during STAR
      trace.delete();
      repeat (5) step(1, 1, 0, 0, 0);
      repeat (5) step(1, 0, 0, 0, 0);
      repeat (25) step(1, 1, 0, 0, 0);
      check("freeze_star", count_of(1), STAR_N + 5);
      step(0, 1, 0, 0, 0);
      repeat (11) step(1, 1, 0, 0, 0);
      check("re_star", state_o, 1);
      step(1, 0, 1, 0, 0);
      check("estop_noena", state_o, 5);

      // Async reset in DELTA
      step(0, 1, 0, 0, 1);
      run_until(3, 80);
      #3;
      reset = 1'b1;
      #1;
      check("areset_outs", {k_main, k_star, k_delta, running, fault}, 0);
      check("areset_state", state_o, 0);
      m_phase = 0; m_left = 0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(0, 1, 0, 0, 0);

      // Randomized traffic
      r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) r = ~r;
         e = ($urandom_range(0, 9) != 0);
         step(r, e, ($urandom_range(0, 299) == 0), ($urandom_range(0, 299) == 0),
              ($urandom_range(0, 7) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
